codec_config_sequencer: RTL

//  Configures the WM8731 audio codec over I2C after reset, before pedal-board samples flow.
//  - Walks a fixed register table and issues one 3-byte I2C write per entry.
//  - Retries an entry that is not acknowledged (NACK).
//  - Raises INIT_FINISH when the table is done; the top-level Init->Read FSM gates on it.
//  - Sits between that top-level FSM and the codec's I2C pins.

---
 rtl/codec_cfg_pkg.sv | 33 +++
 rtl/codec_config_sequencer_if.sv | 18 +
 rtl/i2c_bit_tick.sv | 26 ++
 rtl/codec_config_sequencer.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/codec_cfg_pkg.sv
// codec_cfg_pkg: WM8731 register table, sequencer state encoding and I2C byte helper.
package codec_cfg_pkg;

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } codec_reg_t;

    localparam int CODEC_TABLE_LEN = 11;

    // Index 0 is the leftmost element: R15 reset first, R9 activates the codec last.
    localparam codec_reg_t [0:CODEC_TABLE_LEN-1] CODEC_INIT_TABLE = {
        codec_reg_t'{7'd15, 9'h000},
        codec_reg_t'{7'd6,  9'h000},
        codec_reg_t'{7'd0,  9'h017},
        codec_reg_t'{7'd1,  9'h017},
        codec_reg_t'{7'd2,  9'h079},
        codec_reg_t'{7'd3,  9'h079},
        codec_reg_t'{7'd4,  9'h012},
        codec_reg_t'{7'd5,  9'h000},
        codec_reg_t'{7'd7,  9'h001},
        codec_reg_t'{7'd8,  9'h000},
        codec_reg_t'{7'd9,  9'h001}
    };

    typedef enum logic [2:0] {IDLE, START, SHIFT, ACK, STOP, GAP, DONE, FAIL} seq_state_t;

    function automatic logic [7:0] tx_byte(input logic [7:0] dev, input codec_reg_t e,
                                           input logic [1:0] sel);
        return sel == 2'd0 ? dev : sel == 2'd1 ? {e.addr, e.data[8]} : e.data[7:0];
    endfunction

endpackage

// File: rtl/codec_config_sequencer_if.sv
// codec_config_sequencer_if: control flags and I2C pins between the sequencer and the board.
// vol_in exists only when CODEC_VOL_UPDATE_EN is defined.
interface codec_config_sequencer_if;
    logic INIT;
    logic INIT_FINISH;
    logic ERROR;
    logic I2C_SCLK;
    logic sda_in;
    logic sda_oe;
`ifdef CODEC_VOL_UPDATE_EN
    logic [6:0] vol_in;
    modport master (input INIT, sda_in, vol_in, output INIT_FINISH, ERROR, I2C_SCLK, sda_oe);
    modport slave (output INIT, sda_in, vol_in, input INIT_FINISH, ERROR, I2C_SCLK, sda_oe);
`else
    modport master (input INIT, sda_in, output INIT_FINISH, ERROR, I2C_SCLK, sda_oe);
    modport slave (output INIT, sda_in, input INIT_FINISH, ERROR, I2C_SCLK, sda_oe);
`endif
endinterface

// File: rtl/i2c_bit_tick.sv
// i2c_bit_tick: one-clock qtick strobe every QDIV clocks; an I2C bit spans four qticks.
module i2c_bit_tick #(
    parameter int QDIV = 125
) (
    input  logic Clk,
    input  logic Reset,
    output logic o_qtick
);
    localparam int CW = QDIV > 1 ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] r_cnt;
    logic          r_qtick;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_cnt   <= '0;
            r_qtick <= 1'b0;
        end else begin
            r_qtick <= r_cnt == LAST;
            r_cnt   <= r_cnt == LAST ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_qtick = r_qtick;
endmodule

// File: rtl/codec_config_sequencer.sv
// codec_config_sequencer: writes the WM8731 init table over I2C, one 3-byte write per entry, NACK retry.
// CODEC_VOL_UPDATE_EN: after init, every vol_in change rewrites R2 for both headphone channels.
module codec_config_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         CLK_HZ    = 50_000_000,
    parameter int         I2C_HZ    = 100_000,
    parameter int         NUM_REGS  = 11,
    parameter int         MAX_RETRY = 3,
    parameter logic [7:0] DEV_ADDR  = 8'h34
) (
    input logic Clk,
    input logic Reset,
    codec_config_sequencer_if.master bus
);
    localparam int QDIV = CLK_HZ / (4 * I2C_HZ);
    localparam int IW   = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
    localparam int RW   = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;

    seq_state_t      r_state;
    logic [1:0]      r_ph;
    logic [1:0]      r_byte;
    logic [2:0]      r_bit;
    logic [IW-1:0]   r_idx;
    logic [RW-1:0]   r_retry;
    logic            r_nack;
    logic            r_scl;
    logic            r_sda_oe;
    logic            r_init_finish;
    logic            r_error;
    logic            w_qtick;
    logic            w_last;
    codec_reg_t      w_entry;
    logic [7:0]      w_tx_byte;

    i2c_bit_tick #(.QDIV(QDIV)) u_tick (.Clk(Clk), .Reset(Reset), .o_qtick(w_qtick));

`ifdef CODEC_VOL_UPDATE_EN
    logic [6:0] r_vol_s1;
    logic [6:0] r_vol_s2;
    logic [6:0] r_vol_seen;
    logic [6:0] r_vol_data;
    logic       r_vol_pend;
    logic       r_vol_wr;

    // A pending request is consumed when DONE launches the write; changes during a write re-arm it once.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_vol_s1   <= '0;
            r_vol_s2   <= '0;
            r_vol_seen <= '0;
            r_vol_pend <= 1'b0;
        end else begin
            r_vol_s1   <= bus.vol_in;
            r_vol_s2   <= r_vol_s1;
            r_vol_seen <= r_vol_s2;
            if ((r_state == DONE && r_vol_pend) || r_state == IDLE)
                r_vol_pend <= 1'b0;
            else if (r_vol_s2 != r_vol_seen && (r_state == DONE || (r_vol_wr && r_state != FAIL)))
                r_vol_pend <= 1'b1;
        end
    end

    assign w_entry = r_vol_wr ? codec_reg_t'{7'd2, {2'b10, r_vol_data}} : CODEC_INIT_TABLE[r_idx];
`else
    assign w_entry = CODEC_INIT_TABLE[r_idx];
`endif

    assign w_tx_byte = tx_byte(DEV_ADDR, w_entry, r_byte);
    assign w_last    = r_idx == IW'(NUM_REGS - 1);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state       <= IDLE;
            r_ph          <= '0;
            r_byte        <= '0;
            r_bit         <= '0;
            r_idx         <= '0;
            r_retry       <= '0;
            r_nack        <= 1'b0;
            r_scl         <= 1'b1;
            r_sda_oe      <= 1'b0;
            r_init_finish <= 1'b0;
            r_error       <= 1'b0;
`ifdef CODEC_VOL_UPDATE_EN
            r_vol_wr      <= 1'b0;
            r_vol_data    <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_ph          <= '0;
                    r_idx         <= '0;
                    r_retry       <= '0;
                    r_init_finish <= 1'b0;
                    r_error       <= 1'b0;
`ifdef CODEC_VOL_UPDATE_EN
                    r_vol_wr      <= 1'b0;
`endif
                    if (bus.INIT) r_state <= START;
                end
                START: if (w_qtick) begin
                    if (r_ph == 2'd0) begin
                        r_sda_oe <= 1'b1;
                        r_ph     <= 2'd1;
                    end else begin
                        r_scl   <= 1'b0;
                        r_ph    <= '0;
                        r_byte  <= '0;
                        r_bit   <= 3'd7;
                        r_nack  <= 1'b0;
                        r_state <= SHIFT;
                    end
                end
                // Data bits and the ACK slot share the SCL low / SDA set / SCL high / sample rhythm.
                SHIFT, ACK: if (w_qtick) begin
                    r_ph <= r_ph + 2'd1;
                    case (r_ph)
                        2'd0: r_scl <= 1'b0;
                        2'd1: r_sda_oe <= r_state == ACK ? 1'b0 : ~w_tx_byte[r_bit];
                        2'd2: r_scl <= 1'b1;
                        default: begin
                            if (r_state == SHIFT) begin
                                if (r_bit == 3'd0) r_state <= ACK;
                                else r_bit <= r_bit - 3'd1;
                            end else if (bus.sda_in) begin
                                r_nack  <= 1'b1;
                                r_state <= STOP;
                            end else if (r_byte == 2'd2 || !bus.INIT) begin
                                r_state <= STOP;
                            end else begin
                                r_byte  <= r_byte + 2'd1;
                                r_bit   <= 3'd7;
                                r_state <= SHIFT;
                            end
                        end
                    endcase
                end
                STOP: if (w_qtick) begin
                    r_ph <= r_ph + 2'd1;
                    case (r_ph)
                        2'd0: r_scl <= 1'b0;
                        2'd1: r_sda_oe <= 1'b1;
                        2'd2: r_scl <= 1'b1;
                        default: begin
                            r_sda_oe <= 1'b0;
                            r_state  <= GAP;
                        end
                    endcase
                end
                GAP: if (w_qtick) begin
                    r_ph <= r_ph + 2'd1;
                    if (r_ph == 2'd3) begin
                        if (!bus.INIT) begin
                            r_state <= IDLE;
                        end else if (r_nack) begin
                            if (r_retry == RW'(MAX_RETRY)) r_state <= FAIL;
                            else begin
                                r_retry <= r_retry + 1'b1;
                                r_state <= START;
                            end
`ifdef CODEC_VOL_UPDATE_EN
                        end else if (r_vol_wr) begin
                            r_vol_wr <= 1'b0;
                            r_retry  <= '0;
                            r_state  <= DONE;
`endif
                        end else begin
                            r_retry <= '0;
                            if (w_last) r_state <= DONE;
                            else begin
                                r_idx   <= r_idx + 1'b1;
                                r_state <= START;
                            end
                        end
                    end
                end
                DONE: begin
                    r_init_finish <= 1'b1;
                    if (!bus.INIT) r_state <= IDLE;
`ifdef CODEC_VOL_UPDATE_EN
                    else if (r_vol_pend) begin
                        r_vol_wr   <= 1'b1;
                        r_vol_data <= r_vol_s2;
                        r_state    <= START;
                    end
`endif
                end
                FAIL: begin
                    r_error <= 1'b1;
                    if (!bus.INIT) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.INIT_FINISH = r_init_finish;
    assign bus.ERROR       = r_error;
    assign bus.I2C_SCLK    = r_scl;
    assign bus.sda_oe      = r_sda_oe;
endmodule
